// File: rtl/nora_mst_arbiter_pkg.sv
// Shared constants and types for the NORA master-port arbiter and its round-robin picker.
package nora_mst_arbiter_pkg;

    localparam int NORA_ADDR_W = 24;
    localparam int NORA_DATA_W = 8;
    localparam int OWNER_W     = 3;

    localparam logic [NORA_DATA_W-1:0] NORA_ERR_DATA = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Request as seen by the bus controller; other is already masked by sram.
    typedef struct packed {
        logic [NORA_ADDR_W-1:0] addr;
        logic [NORA_DATA_W-1:0] data;
        logic                   rwn;
        logic                   sram;
        logic                   other;
    } nora_req_t;

endpackage

// File: rtl/nora_mst_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to the lowest index.
module nora_mst_arbiter_rr_pick
    import nora_mst_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [OWNER_W-1:0] idx,
    output logic               vld
);

    logic [N-1:0]       upper_s;
    logic [OWNER_W-1:0] up_idx_s;
    logic [OWNER_W-1:0] any_idx_s;

    // Requesters at or above the pointer take precedence over wrapped ones.
    always_comb begin
        upper_s   = '0;
        up_idx_s  = '0;
        any_idx_s = '0;
        for (int k = 0; k < N; k++) begin
            upper_s[k] = req[k] & (OWNER_W'(k) >= ptr);
        end
        for (int k = N - 1; k >= 0; k--) begin
            up_idx_s  = upper_s[k] ? OWNER_W'(k) : up_idx_s;
            any_idx_s = req[k]     ? OWNER_W'(k) : any_idx_s;
        end
    end

    assign idx = (|upper_s) ? up_idx_s : any_idx_s;
    assign vld = |req;

endmodule

// File: rtl/nora_mst_arbiter.sv
// Round-robin sharing of the NORA master port between N_MST masters, one access in flight,
// with a watchdog that aborts accesses the bus controller never acknowledges.
module nora_mst_arbiter
    import nora_mst_arbiter_pkg::*;
#(
    parameter int N_MST       = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk6x,
    input  logic                         reset,
    input  logic [N_MST-1:0]             m_req_sram_i,
    input  logic [N_MST-1:0]             m_req_other_i,
    input  logic [N_MST-1:0]             m_rwn_i,
    input  logic [N_MST-1:0]             m_lock_i,
    input  logic [NORA_ADDR_W*N_MST-1:0] m_addr_i,
    input  logic [NORA_DATA_W*N_MST-1:0] m_datawr_i,
    output logic [N_MST-1:0]             m_ack_o,
    output logic                         m_err_o,
    output logic [NORA_DATA_W-1:0]       m_datard_o,
    output logic [NORA_ADDR_W-1:0]       nora_mst_addr_o,
    output logic [NORA_DATA_W-1:0]       nora_mst_data_o,
    output logic                         nora_mst_rwn_o,
    output logic                         nora_mst_req_SRAM_o,
    output logic                         nora_mst_req_OTHER_o,
    input  logic                         nora_mst_ack_i,
    input  logic [NORA_DATA_W-1:0]       nora_mst_datard_i,
    output logic                         busy_o,
    output logic [OWNER_W-1:0]           owner_o
);

    localparam int                 CNT_W     = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic               TMO_EN    = (TIMEOUT_CYC != 0) ? 1'b1 : 1'b0;
    localparam logic [OWNER_W-1:0] LAST_MST  = OWNER_W'(N_MST - 1);

    logic [1:0]         state_r;
    logic [OWNER_W-1:0] ptr_r;
    logic [OWNER_W-1:0] owner_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               lock_r;
    nora_req_t          snap_r;

    logic [N_MST-1:0]   req_s;
    logic [N_MST-1:0]   sel_hot_s;
    logic [N_MST-1:0]   own_hot_s;
    logic [OWNER_W-1:0] pick_idx_s;
    logic [OWNER_W-1:0] sel_s;
    logic               pick_vld_s;
    nora_req_t          snap_s;
    logic               owner_req_s;
    logic               owner_lock_s;
    logic               ack_s;
    logic               tmo_s;
    logic               done_s;
    logic               deliver_s;

    assign req_s = m_req_sram_i | m_req_other_i;

    nora_mst_arbiter_rr_pick #(
        .N (N_MST)
    ) u_pick (
        .req (req_s),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .vld (pick_vld_s)
    );

    // A relock in DRAIN re-snapshots the current owner instead of the picker's choice.
    assign sel_s = (state_r == ST_DRAIN) ? owner_r : pick_idx_s;

    // One-hot master selection and the request snapshot muxed from it.
    always_comb begin
        snap_s    = '0;
        sel_hot_s = '0;
        own_hot_s = '0;
        for (int k = 0; k < N_MST; k++) begin
            sel_hot_s[k] = (sel_s == OWNER_W'(k));
            own_hot_s[k] = (owner_r == OWNER_W'(k));
            snap_s.addr  = snap_s.addr | ({NORA_ADDR_W{sel_hot_s[k]}} & m_addr_i[k*NORA_ADDR_W +: NORA_ADDR_W]);
            snap_s.data  = snap_s.data | ({NORA_DATA_W{sel_hot_s[k]}} & m_datawr_i[k*NORA_DATA_W +: NORA_DATA_W]);
            snap_s.rwn   = snap_s.rwn  | (sel_hot_s[k] & m_rwn_i[k]);
            snap_s.sram  = snap_s.sram | (sel_hot_s[k] & m_req_sram_i[k]);
            snap_s.other = snap_s.other | (sel_hot_s[k] & m_req_other_i[k] & ~m_req_sram_i[k]);
        end
    end

    assign owner_req_s  = |(own_hot_s & req_s);
    assign owner_lock_s = |(own_hot_s & m_lock_i);

    // Ack beats timeout; a reset cycle never completes an access toward a master.
    assign ack_s     = (state_r == ST_GRANT) & nora_mst_ack_i & ~reset;
    assign tmo_s     = (state_r == ST_GRANT) & ~nora_mst_ack_i & ~reset & TMO_EN & (cnt_r == CNT_LIMIT);
    assign done_s    = ack_s | tmo_s;
    assign deliver_s = done_s & owner_req_s;

    assign m_ack_o = {N_MST{deliver_s}} & own_hot_s;
    assign m_err_o = deliver_s & tmo_s;

    // Read data path back to the winning master.
    always_comb begin
        if (!deliver_s) begin
            m_datard_o = '0;
        end else if (ack_s) begin
            m_datard_o = nora_mst_datard_i;
        end else begin
            m_datard_o = NORA_ERR_DATA;
        end
    end

    // Arbitration FSM, snapshot registers and saturating watchdog.
    always_ff @(posedge clk6x) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
            cnt_r   <= '0;
            lock_r  <= 1'b0;
            snap_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        snap_r  <= snap_s;
                        owner_r <= pick_idx_s;
                        cnt_r   <= '0;
                        state_r <= ST_GRANT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (done_s) begin
                        snap_r.sram  <= 1'b0;
                        snap_r.other <= 1'b0;
                        lock_r       <= owner_lock_s;
                        state_r      <= ST_DRAIN;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_DRAIN: begin
                    if (lock_r && owner_req_s) begin
                        snap_r  <= snap_s;
                        cnt_r   <= '0;
                        state_r <= ST_GRANT;
                    end else begin
                        ptr_r   <= (owner_r == LAST_MST) ? '0 : owner_r + OWNER_W'(1);
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign nora_mst_addr_o      = snap_r.addr;
    assign nora_mst_data_o      = snap_r.data;
    assign nora_mst_rwn_o       = snap_r.rwn;
    assign nora_mst_req_SRAM_o  = snap_r.sram;
    assign nora_mst_req_OTHER_o = snap_r.other;
    assign busy_o               = (state_r != ST_IDLE);
    assign owner_o              = owner_r;

endmodule

// File: tb/tb_nora_mst_arbiter.sv
// Scoreboard bench for nora_mst_arbiter: bus-controller responder, auto-releasing masters, per-feature tasks.
module tb_nora_mst_arbiter;

    localparam int N   = 3;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  m_req_sram_i, m_req_other_i, m_rwn_i, m_lock_i;
    logic [24*N-1:0] m_addr_i;
    logic [8*N-1:0]  m_datawr_i;
    logic [N-1:0]  m_ack_o;
    logic          m_err_o;
    logic [7:0]    m_datard_o;
    logic [23:0]   nora_mst_addr_o;
    logic [7:0]    nora_mst_data_o;
    logic          nora_mst_rwn_o, nora_mst_req_SRAM_o, nora_mst_req_OTHER_o;
    logic          nora_mst_ack_i;
    logic [7:0]    nora_mst_datard_i;
    logic          busy_o;
    logic [2:0]    owner_o;

    nora_mst_arbiter #(.N_MST(N), .TIMEOUT_CYC(TMO)) dut (
        .clk6x(clk), .reset(reset),
        .m_req_sram_i(m_req_sram_i), .m_req_other_i(m_req_other_i), .m_rwn_i(m_rwn_i),
        .m_lock_i(m_lock_i), .m_addr_i(m_addr_i), .m_datawr_i(m_datawr_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_datard_o(m_datard_o),
        .nora_mst_addr_o(nora_mst_addr_o), .nora_mst_data_o(nora_mst_data_o),
        .nora_mst_rwn_o(nora_mst_rwn_o), .nora_mst_req_SRAM_o(nora_mst_req_SRAM_o),
        .nora_mst_req_OTHER_o(nora_mst_req_OTHER_o), .nora_mst_ack_i(nora_mst_ack_i),
        .nora_mst_datard_i(nora_mst_datard_i), .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  own;
        logic        err;
        logic [7:0]  rd;
        logic [23:0] addr;
        logic [7:0]  wd;
        logic        rwn;
        logic        sram;
    } exp_t;

    exp_t sb[$];
    int   order[$];
    int   errors = 0, checks = 0, cyc = 0, ack_cnt = 0, bus_acks = 0;
    bit   resp_en = 1'b0;
    int   lat = 2;
    int   rem[N];
    bit   ack_seen[N];
    bit   burst_inc = 1'b0;

    function automatic logic [7:0] fdat(input logic [23:0] a);
        return a[7:0] ^ 8'hE0;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus controller model: acks in the lat-th cycle of a downstream request.
    initial begin : responder
        int wc;
        wc = 0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                nora_mst_ack_i = 1'b0;
                if (nora_mst_req_SRAM_o || nora_mst_req_OTHER_o) begin
                    if (wc == lat - 1) begin
                        nora_mst_ack_i    = 1'b1;
                        nora_mst_datard_i = fdat(nora_mst_addr_o);
                        wc = 0;
                        bus_acks++;
                    end else begin
                        wc++;
                    end
                end else begin
                    wc = 0;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Scoreboard monitor: every m_ack_o pulse is matched against the oldest expectation.
    initial begin : monitor
        exp_t e;
        logic [N-1:0] ea;
        forever begin
            @(negedge clk);
            #1;
            if (m_ack_o !== '0) begin
                ack_cnt++;
                checks++;
                if (!$onehot(m_ack_o)) begin
                    errors++;
                    $display("FAIL ack_onehot got=%b", m_ack_o);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack got=%b", m_ack_o);
                end else begin
                    e = sb.pop_front();
                    ea = '0;
                    ea[e.own] = 1'b1;
                    if (m_ack_o !== ea || m_err_o !== e.err || m_datard_o !== e.rd ||
                        nora_mst_addr_o !== e.addr || nora_mst_data_o !== e.wd ||
                        nora_mst_rwn_o !== e.rwn || nora_mst_req_SRAM_o !== e.sram ||
                        nora_mst_req_OTHER_o !== !e.sram) begin
                        errors++;
                        $display("FAIL ack_record got ack=%b err=%b rd=%h addr=%h wd=%h rwn=%b s=%b o=%b exp ack=%b err=%b rd=%h addr=%h wd=%h rwn=%b s=%b o=%b",
                                 m_ack_o, m_err_o, m_datard_o, nora_mst_addr_o, nora_mst_data_o,
                                 nora_mst_rwn_o, nora_mst_req_SRAM_o, nora_mst_req_OTHER_o,
                                 ea, e.err, e.rd, e.addr, e.wd, e.rwn, e.sram, !e.sram);
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (m_ack_o[k]) begin
                        ack_seen[k] = 1'b1;
                        order.push_back(k);
                    end
                end
            end
        end
    end

    // Masters: after an ack, drop the request when done, otherwise step the address (bursts).
    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (ack_seen[k]) begin
                ack_seen[k] = 1'b0;
                if (rem[k] > 0) rem[k]--;
                if (rem[k] == 0) begin
                    m_req_sram_i[k]  = 1'b0;
                    m_req_other_i[k] = 1'b0;
                    m_lock_i[k]      = 1'b0;
                end else begin
                    if (burst_inc) m_addr_i[k*24 +: 24] = m_addr_i[k*24 +: 24] + 24'd1;
                    if (rem[k] == 1) m_lock_i[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "bench did not finish");
    end

    task automatic set_m(input int k, input logic s, input logic o, input logic rwn, input logic lk,
                         input logic [23:0] a, input logic [7:0] d);
        m_req_sram_i[k]  = s;
        m_req_other_i[k] = o;
        m_rwn_i[k]       = rwn;
        m_lock_i[k]      = lk;
        m_addr_i[k*24 +: 24] = a;
        m_datawr_i[k*8 +: 8] = d;
    endtask

    task automatic push_exp(input int k, input logic err, input logic [23:0] a, input logic [7:0] wd,
                            input logic rwn, input logic sram);
        exp_t e;
        e.own  = 3'(k);
        e.err  = err;
        e.rd   = err ? 8'hFF : fdat(a);
        e.addr = a;
        e.wd   = wd;
        e.rwn  = rwn;
        e.sram = sram;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        resp_en = 1'b0;
        burst_inc = 1'b0;
        nora_mst_ack_i = 1'b0;
        nora_mst_datard_i = 8'h00;
        m_req_sram_i = '0; m_req_other_i = '0; m_rwn_i = '0; m_lock_i = '0;
        m_addr_i = '0; m_datawr_i = '0;
        sb.delete();
        order.delete();
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            ack_seen[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o || (rem[0] + rem[1] + rem[2]) != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s wait_timeout pending=%0d busy=%b", name, sb.size(), busy_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({m_ack_o, m_err_o, m_datard_o, nora_mst_addr_o, nora_mst_data_o, nora_mst_rwn_o,
             nora_mst_req_SRAM_o, nora_mst_req_OTHER_o, busy_o, owner_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b addr=%h busy=%b owner=%0d exp all zero",
                     m_ack_o, nora_mst_addr_o, busy_o, owner_o);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        resp_en = 1'b1;
        lat = 4;
        push_exp(0, 1'b0, 24'h012345, 8'h00, 1'b1, 1'b1);
        set_m(0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h012345, 8'h00);
        rem[0] = 1;
        @(negedge clk);
        checks++;
        if (nora_mst_req_SRAM_o !== 1'b1 || nora_mst_addr_o !== 24'h012345 || nora_mst_req_OTHER_o !== 1'b0) begin
            errors++;
            $display("FAIL single_req_latency got sram=%b other=%b addr=%h exp 1 0 012345",
                     nora_mst_req_SRAM_o, nora_mst_req_OTHER_o, nora_mst_addr_o);
        end
        wait_done("single_read");
    endtask

    task automatic test_fairness();
        do_reset();
        resp_en = 1'b1;
        lat = 2;
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 1'b0, 24'h000111, 8'h10, 1'b1, 1'b1);
            push_exp(1, 1'b0, 24'h000222, 8'h11, 1'b1, 1'b1);
            push_exp(2, 1'b0, 24'h000333, 8'h12, 1'b1, 1'b1);
        end
        set_m(0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000111, 8'h10);
        set_m(1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000222, 8'h11);
        set_m(2, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000333, 8'h12);
        rem[0] = 2; rem[1] = 2; rem[2] = 2;
        wait_done("fairness");
        checks++;
        if (order.size() != 6) begin
            errors++;
            $display("FAIL fair_count got=%0d exp=6", order.size());
        end
        for (int i = 1; i < order.size(); i++) begin
            checks++;
            if (order[i] == order[i-1]) begin
                errors++;
                $display("FAIL fair_repeat at=%0d got=%0d exp!=%0d", i, order[i], order[i-1]);
            end
        end
    endtask

    task automatic test_burst_lock();
        do_reset();
        resp_en = 1'b1;
        lat = 2;
        burst_inc = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(1, 1'b0, 24'h000400 + 24'(i), 8'h5C, 1'b0, 1'b1);
        push_exp(2, 1'b0, 24'h00ABCD, 8'h77, 1'b1, 1'b0);
        set_m(1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000400, 8'h5C);
        set_m(2, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00ABCD, 8'h77);
        rem[1] = 4; rem[2] = 1;
        wait_done("burst_lock");
    endtask

    task automatic test_timeout();
        int n, t0, t1, a0;
        do_reset();
        push_exp(0, 1'b1, 24'h000777, 8'h00, 1'b1, 1'b1);
        set_m(0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000777, 8'h00);
        rem[0] = 1;
        a0 = ack_cnt;
        n = 0;
        while (nora_mst_req_SRAM_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        n = 0;
        while (ack_cnt == a0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        t1 = cyc;
        checks++;
        if (n >= 40 || t1 - t0 != TMO) begin
            errors++;
            $display("FAIL timeout_cycles got=%0d exp=%0d", t1 - t0, TMO);
        end
        @(negedge clk);
        nora_mst_ack_i = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== '0) begin
            errors++;
            $display("FAIL late_ack got=%b exp=000", m_ack_o);
        end
        @(negedge clk);
        nora_mst_ack_i = 1'b0;
        wait_done("timeout");
        checks++;
        if (ack_cnt != a0 + 1) begin
            errors++;
            $display("FAIL timeout_ack_count got=%0d exp=%0d", ack_cnt - a0, 1);
        end
    endtask

    task automatic test_ack_vs_timeout();
        do_reset();
        resp_en = 1'b1;
        lat = TMO + 1;
        push_exp(0, 1'b0, 24'h000321, 8'h00, 1'b1, 1'b1);
        set_m(0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000321, 8'h00);
        rem[0] = 1;
        wait_done("ack_vs_timeout");
    endtask

    task automatic test_abort_drop();
        int b0;
        do_reset();
        resp_en = 1'b1;
        lat = 4;
        b0 = bus_acks;
        push_exp(1, 1'b0, 24'h000066, 8'h22, 1'b1, 1'b1);
        set_m(0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000055, 8'h21);
        set_m(1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000066, 8'h22);
        rem[1] = 1;
        repeat (2) @(negedge clk);
        m_req_sram_i[0] = 1'b0;
        wait_done("abort_drop");
        checks++;
        if (bus_acks - b0 != 2) begin
            errors++;
            $display("FAIL abort_bus_acks got=%0d exp=2", bus_acks - b0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000099, 8'h31);
        rem[1] = 1;
        @(negedge clk);
        set_m(0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000088, 8'h30);
        rem[0] = 1;
        @(negedge clk);
        reset = 1'b1;
        nora_mst_ack_i = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== '0) begin
            errors++;
            $display("FAIL reset_kill_ack got=%b exp=000", m_ack_o);
        end
        @(negedge clk);
        checks++;
        if (nora_mst_req_SRAM_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_req got req=%b busy=%b exp 0 0", nora_mst_req_SRAM_o, busy_o);
        end
        nora_mst_ack_i = 1'b0;
        reset = 1'b0;
        resp_en = 1'b1;
        lat = 2;
        push_exp(0, 1'b0, 24'h000088, 8'h30, 1'b1, 1'b1);
        push_exp(1, 1'b0, 24'h000099, 8'h31, 1'b1, 1'b1);
        wait_done("reset_mid");
    endtask

    task automatic test_sram_other();
        do_reset();
        resp_en = 1'b1;
        lat = 3;
        push_exp(2, 1'b0, 24'h00BEEF, 8'h44, 1'b0, 1'b1);
        set_m(2, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00BEEF, 8'h44);
        rem[2] = 1;
        @(negedge clk);
        checks++;
        if (nora_mst_req_SRAM_o !== 1'b1 || nora_mst_req_OTHER_o !== 1'b0 || owner_o !== 3'd2) begin
            errors++;
            $display("FAIL sram_wins got sram=%b other=%b owner=%0d exp 1 0 2",
                     nora_mst_req_SRAM_o, nora_mst_req_OTHER_o, owner_o);
        end
        wait_done("sram_other");
    endtask

    initial begin
        reset = 1'b1;
        nora_mst_ack_i = 1'b0;
        nora_mst_datard_i = 8'h00;
        m_req_sram_i = '0; m_req_other_i = '0; m_rwn_i = '0; m_lock_i = '0;
        m_addr_i = '0; m_datawr_i = '0;
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            ack_seen[k] = 1'b0;
        end
        test_reset();
        test_single_read();
        test_fairness();
        test_burst_lock();
        test_timeout();
        test_ack_vs_timeout();
        test_abort_drop();
        test_reset_mid();
        test_sram_other();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
